// File: rtl/pc_redirect_pkg.sv
// Shared types and defaults for the fetch-PC redirect controller.
// Redirect sources are indexed 0..3 in priority order (exc, eret, jr, mispred).
package pc_redirect_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'hbfc0_0000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc0_0380;
  localparam int          NUM_SRC        = 4;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_EXC     = 3'd1,
    CAUSE_ERET    = 3'd2,
    CAUSE_JR      = 3'd3,
    CAUSE_MISPRED = 3'd4
  } cause_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic        valid;
    cause_e      cause;
    logic [31:0] target;
  } redir_t;

  // Source index i carries cause i+1, so a lower cause code is a higher priority.
  function automatic cause_e cause_of(input int idx);
    return cause_e'(3'(idx + 1));
  endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Combinational priority encoder over the redirect sources; index 0 wins.
module redirect_prio_sel
  import pc_redirect_pkg::*;
(
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC-1:0][31:0] target,
  output redir_t                   sel
);

  always_comb begin
    sel.valid  = 1'b0;
    sel.cause  = CAUSE_NONE;
    sel.target = '0;
    // Walk from lowest to highest priority so the last hit wins.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel.valid  = 1'b1;
        sel.cause  = cause_of(i);
        sel.target = target[i];
      end
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC redirect sequencer: priority select, stall hold, IF/ID flush timer.
// Define REDIRECT_STATS_EN to add saturating per-cause redirect counters.
module pc_redirect_ctrl
  import pc_redirect_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        jr_req,
  input  logic [31:0] jr_target,
  input  logic        mispred_req,
  input  logic        mispred_br,
  input  logic [31:0] br_target,
  input  logic [31:0] pc_id,
  input  logic        pre_take,
  input  logic [31:0] pre_target,
  input  logic [31:0] pc_if,
  output logic [31:0] npc,
  output logic        redirect_valid,
  output logic [2:0]  redirect_cause,
  output logic        flush_if_id
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0] stat_exc,
  output logic [31:0] stat_jr,
  output logic [31:0] stat_mispred
`endif
);

  state_e      state, state_nxt;
  cause_e      pend_cause, pend_cause_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic [2:0]  cnt, cnt_nxt;
  logic        issue;
  cause_e      issue_cause;

  logic [NUM_SRC-1:0]       live_req, hold_req;
  logic [NUM_SRC-1:0][31:0] live_tgt, hold_tgt;
  redir_t                   live_sel, hold_sel;

  assign live_req = {mispred_req, jr_req, eret_req, exc_req};
  assign live_tgt[0] = EXC_VECTOR;
  assign live_tgt[1] = epc;
  assign live_tgt[2] = jr_target;
  assign live_tgt[3] = mispred_br ? br_target : pc_id + 32'd4;

  // In HOLD the pending redirect joins the live sources in its own slot;
  // on a same-slot tie the earlier (pending) target is kept.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state == ST_HOLD && pend_cause == cause_of(i)) begin
        hold_req[i] = 1'b1;
        hold_tgt[i] = pend_target;
      end else begin
        hold_req[i] = live_req[i];
        hold_tgt[i] = live_tgt[i];
      end
    end
  end

  redirect_prio_sel u_live_sel (.req(live_req), .target(live_tgt), .sel(live_sel));
  redirect_prio_sel u_hold_sel (.req(hold_req), .target(hold_tgt), .sel(hold_sel));

  always_comb begin
    state_nxt       = state;
    pend_cause_nxt  = pend_cause;
    pend_target_nxt = pend_target;
    cnt_nxt         = cnt;
    issue           = 1'b0;
    issue_cause     = CAUSE_NONE;
    npc             = stall ? pc_if : (pre_take ? pre_target : pc_if + 32'd4);
    redirect_valid  = 1'b0;
    redirect_cause  = CAUSE_NONE;
    flush_if_id     = (state == ST_FLUSH);

    case (state)
      ST_RUN, ST_FLUSH: begin
        if (live_sel.valid) begin
          if (!stall) begin
            issue       = 1'b1;
            issue_cause = live_sel.cause;
            npc         = live_sel.target;
          end else begin
            pend_cause_nxt  = live_sel.cause;
            pend_target_nxt = live_sel.target;
            npc             = pc_if;
            state_nxt       = ST_HOLD;
          end
        end else if (state == ST_FLUSH && !stall) begin
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) state_nxt = ST_RUN;
        end
      end
      ST_HOLD: begin
        npc = pc_if;
        if (stall) begin
          pend_cause_nxt  = hold_sel.cause;
          pend_target_nxt = hold_sel.target;
        end else begin
          issue       = 1'b1;
          issue_cause = hold_sel.cause;
          npc         = hold_sel.target;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (issue) begin
      redirect_valid  = 1'b1;
      redirect_cause  = issue_cause;
      flush_if_id     = 1'b1;
      state_nxt       = ST_FLUSH;
      cnt_nxt         = 3'(FLUSH_CYCLES);
      pend_cause_nxt  = CAUSE_NONE;
      pend_target_nxt = '0;
    end

    if (rst) begin
      npc            = RESET_PC;
      redirect_valid = 1'b0;
      redirect_cause = CAUSE_NONE;
      flush_if_id    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      pend_cause  <= CAUSE_NONE;
      pend_target <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_nxt;
      pend_cause  <= pend_cause_nxt;
      pend_target <= pend_target_nxt;
      cnt         <= cnt_nxt;
    end
  end

`ifdef REDIRECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_exc     <= '0;
      stat_jr      <= '0;
      stat_mispred <= '0;
    end else if (issue) begin
      case (issue_cause)
        CAUSE_EXC:     if (stat_exc != '1)     stat_exc     <= stat_exc + 32'd1;
        CAUSE_JR:      if (stat_jr != '1)      stat_jr      <= stat_jr + 32'd1;
        CAUSE_MISPRED: if (stat_mispred != '1) stat_mispred <= stat_mispred + 32'd1;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl; honours REDIRECT_STATS_EN when defined.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, exc_req, eret_req, jr_req, mispred_req, mispred_br, pre_take;
  logic [31:0] epc, jr_target, br_target, pc_id, pre_target, pc_if;
  logic [31:0] npc;
  logic        redirect_valid, flush_if_id;
  logic [2:0]  redirect_cause;
`ifdef REDIRECT_STATS_EN
  logic [31:0] stat_exc, stat_jr, stat_mispred;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .jr_req(jr_req), .jr_target(jr_target),
    .mispred_req(mispred_req), .mispred_br(mispred_br), .br_target(br_target),
    .pc_id(pc_id), .pre_take(pre_take), .pre_target(pre_target), .pc_if(pc_if),
    .npc(npc), .redirect_valid(redirect_valid), .redirect_cause(redirect_cause),
    .flush_if_id(flush_if_id)
`ifdef REDIRECT_STATS_EN
    , .stat_exc(stat_exc), .stat_jr(stat_jr), .stat_mispred(stat_mispred)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full output check: npc, redirect_valid, redirect_cause, flush_if_id.
  task automatic chk_out(input string tag, input logic [31:0] e_npc, input logic e_rv,
                         input logic [2:0] e_rc, input logic e_fl);
    chk({tag, ".npc"}, npc, e_npc);
    chk({tag, ".valid"}, {31'd0, redirect_valid}, {31'd0, e_rv});
    chk({tag, ".cause"}, {29'd0, redirect_cause}, {29'd0, e_rc});
    chk({tag, ".flush"}, {31'd0, flush_if_id}, {31'd0, e_fl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    exc_req = 0; eret_req = 0; jr_req = 0; mispred_req = 0; pre_take = 0;
  endtask

  initial begin
    rst = 1; stall = 0; clr_req(); mispred_br = 0;
    epc = 32'h8000_0100; jr_target = 0; br_target = 0; pc_id = 0;
    pre_target = 0; pc_if = 32'hbfc0_0000;

    // Reset: two cycles
    #4; chk_out("reset0", 32'hbfc0_0000, 0, 0, 0);
    tick(); tick();
    #3; chk_out("reset1", 32'hbfc0_0000, 0, 0, 0);
    rst = 0;
    #1; chk_out("seq_after_reset", 32'hbfc0_0004, 0, 0, 0);
    tick();

    // JR, unstalled: same-cycle redirect, two flush cycles, then RUN
    pc_if = 32'h8000_0000; jr_req = 1; jr_target = 32'h8000_1000;
    #4; chk_out("jr_issue", 32'h8000_1000, 1, 3, 1);
    tick(); jr_req = 0; pc_if = 32'h8000_1000;
    #4; chk_out("jr_flush1", 32'h8000_1004, 0, 0, 1);
    tick();
    #4; chk_out("jr_flush2", 32'h8000_1004, 0, 0, 1);
    tick();
    #4; chk_out("jr_run", 32'h8000_1004, 0, 0, 0);
    tick();

    // Mispredict not-taken held across 3 stalled cycles
    pc_if = 32'h8000_0020; pc_id = 32'h8000_0010; mispred_req = 1; mispred_br = 0; stall = 1;
    #4; chk_out("mp_stall0", 32'h8000_0020, 0, 0, 0);
    tick(); mispred_req = 0;
    #4; chk_out("mp_stall1", 32'h8000_0020, 0, 0, 0);
    tick();
    #4; chk_out("mp_stall2", 32'h8000_0020, 0, 0, 0);
    tick(); stall = 0; pc_id = 32'h8000_0040;
    #4; chk_out("mp_release", 32'h8000_0014, 1, 4, 1);
    tick(); tick(); tick();

    // HOLD with pending jr; exc pulses during stall -> exc issues
    jr_req = 1; jr_target = 32'h8000_5000; stall = 1;
    tick(); jr_req = 0; exc_req = 1;
    tick(); exc_req = 0;
    tick(); stall = 0;
    #4; chk_out("hold_jr_then_exc", 32'hbfc0_0380, 1, 1, 1);
    tick(); tick(); tick();

    // Reverse order: exc pending, jr arrives -> exc still issues
    exc_req = 1; stall = 1;
    tick(); exc_req = 0; jr_req = 1; jr_target = 32'h8000_6000;
    tick(); jr_req = 0; stall = 0;
    #4; chk_out("hold_exc_then_jr", 32'hbfc0_0380, 1, 1, 1);
    tick(); tick(); tick();

    // Pending mispred (taken); higher-priority jr on the release cycle wins
    mispred_req = 1; mispred_br = 1; br_target = 32'h8000_3000; stall = 1;
    tick(); mispred_req = 0;
    tick(); stall = 0; jr_req = 1; jr_target = 32'h8000_4000;
    #4; chk_out("release_live_jr", 32'h8000_4000, 1, 3, 1);
    tick(); jr_req = 0; tick(); tick();

    // Simultaneous exc & eret -> exception vector
    exc_req = 1; eret_req = 1;
    #4; chk_out("exc_eret", 32'hbfc0_0380, 1, 1, 1);
    tick(); clr_req(); tick(); tick();

    // ERET alone
    eret_req = 1; epc = 32'h8000_0abc;
    #4; chk_out("eret", 32'h8000_0abc, 1, 2, 1);
    tick(); clr_req(); tick(); tick();

    // Predicted taken, no redirect
    pre_take = 1; pre_target = 32'h8000_2000; pc_if = 32'h8000_1ff0;
    #4; chk_out("pre_take", 32'h8000_2000, 0, 0, 0);
    tick(); pre_take = 0;

    // Stall with no request, then pc_if+4 wrap
    stall = 1;
    #4; chk_out("idle_stall", 32'h8000_1ff0, 0, 0, 0);
    tick(); stall = 0; pc_if = 32'hffff_fffc;
    #4; chk_out("wrap_pc_if", 32'h0000_0000, 0, 0, 0);
    tick();

    // Mispredict not-taken at top of address space wraps pc_id+4
    pc_if = 32'h8000_0000; pc_id = 32'hffff_fffc; mispred_req = 1; mispred_br = 0;
    #4; chk_out("wrap_pc_id", 32'h0000_0000, 1, 4, 1);
    tick(); mispred_req = 0; tick(); tick();

    // Stall freezes the flush counter
    jr_req = 1; jr_target = 32'h8000_7000;
    tick(); jr_req = 0; stall = 1;
    #4; chk("frz_stall0", {31'd0, flush_if_id}, 32'd1);
    tick();
    #4; chk("frz_stall1", {31'd0, flush_if_id}, 32'd1);
    tick(); stall = 0;
    #4; chk("frz_run1", {31'd0, flush_if_id}, 32'd1);
    tick();
    #4; chk("frz_run2", {31'd0, flush_if_id}, 32'd1);
    tick();
    #4; chk("frz_done", {31'd0, flush_if_id}, 32'd0);
    tick();

    // New request mid-FLUSH reloads the counter
    jr_req = 1;
    tick(); jr_req = 0;
    tick(); jr_req = 1; jr_target = 32'h8000_8000;
    #4; chk_out("flush_reissue", 32'h8000_8000, 1, 3, 1);
    tick(); jr_req = 0;
    #4; chk("reload1", {31'd0, flush_if_id}, 32'd1);
    tick();
    #4; chk("reload2", {31'd0, flush_if_id}, 32'd1);
    tick();
    #4; chk("reload_done", {31'd0, flush_if_id}, 32'd0);
    tick();

    // Reset while in HOLD drops the pending redirect
    jr_req = 1; jr_target = 32'h8000_9000; stall = 1;
    tick(); jr_req = 0; rst = 1;
    #4; chk_out("rst_hold", 32'hbfc0_0000, 0, 0, 0);
    tick(); rst = 0; stall = 0; pc_if = 32'hbfc0_0000;
    #4; chk_out("after_rst_hold", 32'hbfc0_0004, 0, 0, 0);
    tick();

`ifdef REDIRECT_STATS_EN
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      jr_req = 1; tick(); jr_req = 0; tick(); tick();
    end
    eret_req = 1; tick(); eret_req = 0; tick(); tick();
    #4;
    chk("stat_jr", stat_jr, 32'd3);
    chk("stat_exc", stat_exc, 32'd0);
    chk("stat_mispred", stat_mispred, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
